iq_snapshot_capture: RTL

Snapshot capture buffer on the output of the I/Q frequency-shift stage. On an arm/trigger sequence it records a burst of consecutive multi-lane I/Q samples into on-chip block RAM at full fabric rate. It then drains the burst through an AXI4-Stream master at up to one word per cycle, for DMA to the processing system.

---
 rtl/iq_snapshot_capture.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/iq_snapshot_capture.sv
// Snapshot capture of multi-lane I/Q samples into block RAM on arm/trigger,
// drained afterwards as an AXI4-Stream burst at up to one word per clock.
module iq_snapshot_capture #(
    parameter int NUMBER_OF_LINE = 8,
    parameter int DEPTH          = 1024,
    parameter int ADDR_W         = $clog2(DEPTH)
) (
    input  logic                          clock,
    input  logic                          resetn,
    input  logic [16*NUMBER_OF_LINE-1:0]  data_in_i,
    input  logic [16*NUMBER_OF_LINE-1:0]  data_in_q,
    input  logic                          arm,
    input  logic                          trigger,
    input  logic                          abort,
    input  logic [ADDR_W:0]               capture_len,
    output logic [32*NUMBER_OF_LINE-1:0]  m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic [1:0]                    state,
    output logic                          done
);
    localparam int              WORD_W  = 32 * NUMBER_OF_LINE;
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE     = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        READOUT = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [WORD_W-1:0] mem [DEPTH];
    logic [WORD_W-1:0] wr_word;
    logic [WORD_W-1:0] ram_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   eff_len;
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_en;
    logic              s1_valid;
    logic              s1_last;
    logic              s1_move;
    logic              issue;
    logic              out_ready;
    logic              final_hs;

    for (genvar k = 0; k < NUMBER_OF_LINE; k++) begin : g_pack
        assign wr_word[32*k +: 16]    = data_in_i[16*k +: 16];
        assign wr_word[32*k+16 +: 16] = data_in_q[16*k +: 16];
    end

    assign eff_len   = (capture_len == '0 || capture_len > DEPTH_W) ? DEPTH_W : capture_len;
    assign wr_en     = !abort && ((state_q == ARMED && trigger) || state_q == CAPTURE);
    assign wr_addr   = (state_q == CAPTURE) ? wr_ptr[ADDR_W-1:0] : '0;

    // ram_q is the read-ahead stage; it only advances when the output register can take its word.
    assign out_ready = !m_axis_tvalid || m_axis_tready;
    assign s1_move   = s1_valid && out_ready;
    assign issue     = (state_q == READOUT) && (rd_ptr < len_q) && (!s1_valid || s1_move);
    assign final_hs  = (state_q == READOUT) && m_axis_tvalid && m_axis_tready && m_axis_tlast;
    assign state     = state_q;

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_word;
        end
        if (issue) begin
            ram_q <= mem[rd_ptr[ADDR_W-1:0]];
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (arm) state_d = ARMED;
                ARMED:   if (trigger) state_d = (len_q == ONE) ? READOUT : CAPTURE;
                CAPTURE: if (wr_ptr == len_q - ONE) state_d = READOUT;
                READOUT: if (final_hs) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            len_q         <= DEPTH_W;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            s1_valid      <= 1'b0;
            s1_last       <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            done          <= 1'b0;
        end else if (abort) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            s1_valid      <= 1'b0;
            s1_last       <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            done          <= 1'b0;
        end else begin
            done <= final_hs;
            if (state_q == IDLE && arm) begin
                len_q <= eff_len;
            end

            // Word 0 is written on the trigger edge, so capture continues from address 1.
            if (state_q == ARMED) begin
                wr_ptr <= trigger ? ONE : '0;
            end else if (state_q == CAPTURE) begin
                wr_ptr <= wr_ptr + ONE;
            end else begin
                wr_ptr <= '0;
            end

            if (state_q == READOUT) begin
                if (issue) begin
                    rd_ptr   <= rd_ptr + ONE;
                    s1_last  <= (rd_ptr == len_q - ONE);
                    s1_valid <= 1'b1;
                end else if (s1_move) begin
                    s1_valid <= 1'b0;
                end
                if (s1_move) begin
                    m_axis_tdata  <= ram_q;
                    m_axis_tvalid <= 1'b1;
                    m_axis_tlast  <= s1_last;
                end else if (m_axis_tready) begin
                    m_axis_tvalid <= 1'b0;
                    m_axis_tlast  <= 1'b0;
                end
            end else begin
                rd_ptr        <= '0;
                s1_valid      <= 1'b0;
                m_axis_tvalid <= 1'b0;
                m_axis_tlast  <= 1'b0;
            end
        end
    end

endmodule
